// File: rtl/run_seq_pkg.sv
// run_seq_pkg: shared types and default constants for the run sequencer.
//   run_state_t      - sequencer state encoding (IDLE, HOLD, RUN, DONE, FAULT)
//   RUN_SEQ_DONE_PC  - default program counter value that marks completion
//   RUN_SEQ_HOLD_CYC - default number of cycles the core is held in reset
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } run_state_t;

    localparam int RUN_SEQ_DONE_PC  = 128;
    localparam int RUN_SEQ_HOLD_CYC = 2;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that clears on request and sticks at all-ones.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, clears the count
//   clr   - synchronous clear (wins over inc)
//   inc   - advance the count by one unless already at all-ones
//   count - current count value
module sat_counter
    import run_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: run control between the host req/done handshake and the
// processor core. A rising edge on req holds the core in reset for HOLD_CYC
// cycles, then enables it until the program counter reaches DONE_PC, at
// which point the core is frozen and done is raised.
// Optional watchdog: define RUN_SEQ_WATCHDOG_EN to abort a run after TIMEOUT
// RUN cycles (FAULT state, timeout=1). Without it timeout is tied low.
// Ports:
//   clk       - system clock
//   reset     - synchronous active-high reset
//   req       - start request (rising edge starts a run)
//   prog_ctr  - core program counter
//   core_rst  - reset to the core
//   core_en   - core advance enable
//   busy      - high while holding or running
//   done      - run finished (normal or watchdog)
//   timeout   - run ended by the watchdog
//   cycle_cnt - RUN cycles in the current or last run (saturating)
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int D        = 12,
    parameter int DONE_PC  = RUN_SEQ_DONE_PC,
    parameter int HOLD_CYC = RUN_SEQ_HOLD_CYC,
    parameter int CW       = 16,
    parameter int TIMEOUT  = 4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  prog_ctr,
    output logic          core_rst,
    output logic          core_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("run_sequencer: HOLD_CYC must be at least 1");
    end

    if ((TIMEOUT < 1) || (longint'(TIMEOUT) > ((longint'(1) << CW) - 1))) begin : g_bad_timeout
        $error("run_sequencer: TIMEOUT must be in 1 .. 2**CW-1");
    end

    run_state_t    state;
    run_state_t    state_nxt;
    logic          req_q;
    logic          start;
    logic          launch;
    logic          pc_hit;
    logic          wd_hit;
    logic [HW-1:0] hold_cnt;

    assign start  = req & ~req_q;
    // Starts are only honoured from a resting state; edges while holding
    // or running are deliberately dropped.
    assign launch = start & ((state == IDLE) || (state == DONE) || (state == FAULT));
    assign pc_hit = (prog_ctr == D'(DONE_PC));

`ifdef RUN_SEQ_WATCHDOG_EN
    // The count has not yet been bumped for the current cycle, so the
    // TIMEOUT-th RUN cycle sees TIMEOUT-1 here.
    assign wd_hit = (cycle_cnt == CW'(TIMEOUT - 1));
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (launch) begin
            hold_cnt <= HW'(HOLD_CYC - 1);
        end else if ((state == HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, FAULT: begin
                if (launch) state_nxt = HOLD;
            end
            HOLD: begin
                if (hold_cnt == '0) state_nxt = RUN;
            end
            RUN: begin
                // A PC match on the watchdog cycle still counts as a clean finish.
                if (pc_hit) begin
                    state_nxt = DONE;
                end else if (wd_hit) begin
                    state_nxt = FAULT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_rst = 1'b1;
        core_en  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        timeout  = 1'b0;
        case (state)
            HOLD: begin
                busy = 1'b1;
            end
            RUN: begin
                core_rst = 1'b0;
                core_en  = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            FAULT: begin
                core_rst = 1'b0;
                done     = 1'b1;
`ifdef RUN_SEQ_WATCHDOG_EN
                timeout  = 1'b1;
`endif
            end
            default: begin
                core_rst = 1'b1;
            end
        endcase
    end

    sat_counter #(
        .WIDTH (CW)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (launch),
        .inc   (state == RUN),
        .count (cycle_cnt)
    );

endmodule
